pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter N, default 16: operand and result width in bits, N >= 2.
REQ-002 SHALL have parameter CHUNK, default 4: carry-chain bits resolved per pipeline stage, 1 <= CHUNK <= N.
REQ-003 SHALL derive local parameter STAGES = ceil(N/CHUNK); the last chunk SHALL hold the remaining N - (STAGES-1)*CHUNK bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 A  input  N  operand A.
REQ-009 B  input  N  operand B.
REQ-010 Cin  input  1  carry-in; used only when sub=0.
REQ-011 sub  input  1  0: A+B+Cin; 1: A-B, computed as A+~B+1.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 Sum  output  N  result bits.
REQ-015 Cout  output  1  raw carry out of bit N-1.
REQ-016 Ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-017 SHALL implement STAGES register stages; stage k SHALL resolve bits [k*CHUNK +: CHUNK] by ripple carry, using the carry registered by stage k-1.
REQ-018 SHALL carry the unresolved upper bits of A and the (possibly inverted) B forward alongside each stage's valid bit.
REQ-019 SHALL compute a global advance enable: adv = !out_valid || out_ready.
REQ-020 SHALL drive in_ready = adv, combinationally.
REQ-021 SHALL transfer an input beat when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-022 SHALL shift all stages, valid bits included, by one when adv=1, and SHALL hold every stage unchanged when adv=0.
REQ-023 SHALL load a bubble (valid=0) into stage 0 when adv=1 and in_valid=0.
REQ-024 SHALL have a latency of exactly STAGES cycles from input transfer to out_valid, with no stall.
REQ-025 SHALL sustain one beat per cycle while out_ready=1.
REQ-026 SHALL keep Sum, Cout and Ovf stable while out_valid=1 and out_ready=0.
REQ-027 SHALL compute Ovf = (carry into bit N-1) XOR (carry out of bit N-1).
REQ-028 SHALL deliver results in input order, without loss or duplication, across any stall pattern.
REQ-029 When CHUNK >= N, SHALL reduce to a single registered stage with latency 1.

Reset
REQ-030 SHALL, while rst=1, asynchronously clear every stage valid bit, making out_valid=0.
REQ-031 SHALL clear Sum, Cout and Ovf to 0 during reset.
REQ-032 SHALL discard in-flight beats on reset mid-operation; no beat SHALL emerge after reset release unless accepted after it.
REQ-033 SHALL assert in_ready=1 during reset, since adv=1 while out_valid=0; beats offered while rst=1 SHALL be dropped.

Configuration
REQ-034 SHALL support macro PIPELINED_ADDER_SAT_EN.
REQ-035 With PIPELINED_ADDER_SAT_EN defined, the output stage SHALL clamp Sum on signed overflow:
  - when Ovf=1 and the sign of the true result is positive, Sum = 2^(N-1)-1;
  - when Ovf=1 and the sign of the true result is negative, Sum = -2^(N-1).
  Cout and Ovf SHALL still report raw values.
REQ-036 Without PIPELINED_ADDER_SAT_EN, Sum SHALL be the raw wrap-around result; no clamp logic SHALL exist.

Verification
REQ-037 N=16, CHUNK=4, sub=0, A=0x00FF, B=0x0001, Cin=0, out_ready=1 -> after 4 cycles Sum=0x0100, Cout=0, Ovf=0.
REQ-038 N=16, sub=1, A=0x0000, B=0x0001 -> Sum=0xFFFF, Cout=0, Ovf=0; A=0x8000, B=0x0001 -> Sum=0x7FFF, Ovf=1 (SAT_EN: Sum=0x8000).
REQ-039 sub=0, A=0x7FFF, B=0x0001, Cin=0 -> Ovf=1; Sum=0x8000 without SAT_EN, 0x7FFF with SAT_EN.
REQ-040 Back-to-back beats 1+1, 2+2, ... 10+10, out_ready toggling 1,0,0,1,... -> Sum sequence 2,4,...,20 in order, no drops, values held while stalled.
REQ-041 Load 3 beats, assert rst for 1 cycle mid-flight -> out_valid=0 immediately, no stale result ever emerges, next accepted beat appears after 4 cycles.
REQ-042 N=5, CHUNK=8 (single stage), A=5'h1F, B=5'h01, Cin=1 -> Sum=5'h01, Cout=1, latency 1.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready flow control.
// Optional signed saturation of Sum on overflow: define PIPELINED_ADDER_SAT_EN.
module pipelined_adder #(
    parameter int unsigned N     = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf
);
    localparam int unsigned STAGES = (N + CHUNK - 1) / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    logic         v_q   [STAGES];
    logic [N-1:0] a_q   [STAGES];
    logic [N-1:0] b_q   [STAGES];
    logic [N-1:0] s_q   [STAGES];
    logic         c_q   [STAGES];
    logic         ovf_q;

    logic [N-1:0] src_a [STAGES];
    logic [N-1:0] src_b [STAGES];
    logic [N-1:0] src_s [STAGES];
    logic         src_c [STAGES];

    logic [N-1:0] a_d   [STAGES];
    logic [N-1:0] b_d   [STAGES];
    logic [N-1:0] s_d   [STAGES];
    logic         c_d   [STAGES];
    logic         ovf_d;

    logic         adv;

    // Whole pipeline moves together; a stalled output freezes every stage.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign Sum       = s_q[LAST];
    assign Cout      = c_q[LAST];
    assign Ovf       = ovf_q;

    // Stage inputs: subtraction enters as A + ~B + 1.
    always_comb begin
        src_a[0] = A;
        src_b[0] = sub ? ~B : B;
        src_s[0] = '0;
        src_c[0] = sub | Cin;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
    end

    // Each stage ripples its own chunk; carry into the MSB is kept for Ovf.
    always_comb begin
        logic cy;
        logic cm;
        cy    = 1'b0;
        cm    = 1'b0;
        ovf_d = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            a_d[k] = src_a[k];
            b_d[k] = src_b[k];
            s_d[k] = src_s[k];
            cy     = src_c[k];
            for (int unsigned i = 0; i < N; i++) begin
                if (i >= k * CHUNK && i < (k + 1) * CHUNK) begin
                    if (i == N - 1) cm = cy;
                    s_d[k][i] = a_d[k][i] ^ b_d[k][i] ^ cy;
                    cy        = (a_d[k][i] & b_d[k][i]) | (cy & (a_d[k][i] ^ b_d[k][i]));
                end
            end
            c_d[k] = cy;
        end
        ovf_d = cm ^ c_d[LAST];
`ifdef PIPELINED_ADDER_SAT_EN
        // On overflow both effective operands share a sign, which is the true result's sign.
        if (ovf_d) begin
            s_d[LAST] = a_d[LAST][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            v_q[0] <= in_valid;
            for (int unsigned k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: random and directed beats checked against an arithmetic model.
module tb_pipelined_adder;
    localparam int unsigned N      = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned STAGES = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, Cin, sub, Cout, Ovf;
    logic         out_ready = 1'b1;
    logic [N-1:0] A, B, Sum;

    logic         in_valid5, in_ready5, out_valid5, Cin5, sub5, Cout5, Ovf5;
    logic         out_ready5 = 1'b1;
    logic [4:0]   A5, B5, Sum5;

    int           pass_cnt = 0;
    int           chk_cnt  = 0;
    int           rdy_mode = 0;
    int           rdy_phase = 0;
    logic [17:0]  exp_q [$];

    pipelined_adder #(.N(N), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    pipelined_adder #(.N(5), .CHUNK(8)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .A(A5), .B(B5), .Cin(Cin5), .sub(sub5),
        .out_valid(out_valid5), .out_ready(out_ready5),
        .Sum(Sum5), .Cout(Cout5), .Ovf(Ovf5)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: true signed/unsigned arithmetic, packed as {Cout, Ovf, Sum}.
    function automatic logic [17:0] model(logic [15:0] a, logic [15:0] b, logic c, logic s);
        int         t;
        logic       co, ov;
        logic [15:0] r;
        if (s) begin
            t  = int'($signed(a)) - int'($signed(b));
            co = (a >= b);
        end else begin
            t  = int'($signed(a)) + int'($signed(b)) + int'(c);
            co = (32'(a) + 32'(b) + 32'(c)) > 32'h0000_FFFF;
        end
        ov = (t > 32767) || (t < -32768);
        r  = 16'(t);
`ifdef PIPELINED_ADDER_SAT_EN
        if (ov) r = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {co, ov, r};
    endfunction

    // Downstream readiness pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (rdy_phase % 3 == 0); rdy_phase++; end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: every cycle with a result present is compared to the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                chk("result", 32'({Cout, Ovf, Sum}), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(logic [N-1:0] a, logic [N-1:0] b, logic c, logic s);
        int g = 0;
        A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 200) begin @(negedge clk); g++; end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        else exp_q.push_back(model(a, b, c, s));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int g = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && g < 500) begin @(posedge clk); #1; g++; end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic lat_test(logic [N-1:0] a, logic [N-1:0] b, logic c, logic s);
        int lat;
        send(a, b, c, s);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", 32'(lat), 32'(STAGES));
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        in_valid5 = 1'b0; A5 = '0; B5 = '0; Cin5 = 1'b0; sub5 = 1'b0;
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       32'(Sum),       32'd0);
        chk("rst_cout",      32'(Cout),      32'd0);
        chk("rst_ovf",       32'(Ovf),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-stage configuration: 1F + 01 + 1.
        A5 = 5'h1F; B5 = 5'h01; Cin5 = 1'b1; in_valid5 = 1'b1;
        chk("s1_in_ready", 32'(in_ready5), 32'd1);
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        chk("s1_valid", 32'(out_valid5), 32'd1);
        chk("s1_sum",   32'(Sum5),       32'h01);
        chk("s1_cout",  32'(Cout5),      32'd1);
        chk("s1_ovf",   32'(Ovf5),       32'd0);
        @(posedge clk); #1;
        chk("s1_bubble", 32'(out_valid5), 32'd0);

        // Directed corner cases.
        lat_test(16'h00FF, 16'h0001, 1'b0, 1'b0);
        send(16'h0000, 16'h0001, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send(16'h1234, 16'h1234, 1'b1, 1'b1);
        drain();

        // Back-to-back beats under a 1,0,0 readiness pattern.
        rdy_mode = 1;
        for (int i = 1; i <= 10; i++) send(N'(i), N'(i), 1'b0, 1'b0);
        drain();

        // Reset with beats in flight and a stalled result at the output.
        rdy_mode = 3;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(N'(16'h0100 + i), 16'h0011, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("stalled_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        A = 16'h5555; B = 16'h1111; in_valid = 1'b1;
        #1;
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_sum",      32'(Sum),       32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; rdy_mode = 0;
        repeat (10) begin @(posedge clk); #1; end
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        lat_test(16'h0F0F, 16'h00F1, 1'b1, 1'b0);

        // Randomized traffic with random gaps and backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
        end
        rdy_mode = 0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
